// File: rtl/gpu_sched_pkg.sv
// Shared types for the GPU command scheduler: FSM states, the command record
// and the read/write encoding of the rw bit.
package gpu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RENDER = 2'd2
  } state_e;

  localparam int CMD_OP_W   = 8;
  localparam int CMD_DATA_W = 16;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  typedef struct packed {
    logic                  rw;
    logic [CMD_OP_W-1:0]   op;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Show-ahead FIFO of command records; head entry is visible on rd_data while
// not empty. Full/empty derive from the occupancy count.
module gpu_cmd_fifo
  import gpu_sched_pkg::*;
#(
  parameter int  DEPTH  = 16,
  parameter type item_t = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  item_t                    wr_data,
  input  logic                     pop,
  output item_t                    rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  item_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Orders GPU commands around frame renders: writes are held while rendering,
// reads bypass them, and held writes drain before the next render is granted.
module gpu_cmd_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OP_W       = 8,
  parameter int DATA_W     = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          cmd_valid,
  input  logic                          cmd_rw,
  input  logic [OP_W-1:0]               cmd_op,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic                          cmd_ready,
  output logic                          exec_valid,
  output logic                          exec_rw,
  output logic [OP_W-1:0]               exec_op,
  output logic [DATA_W-1:0]             exec_data,
  input  logic                          exec_ready,
  input  logic                          frame_req,
  output logic                          frame_gnt,
  input  logic                          render_done,
  output logic                          rendering,
  output logic [$clog2(FIFO_DEPTH):0]   held_count,
  output state_e                        fsm_state
);

  // Both ports are valid/ready: a transfer happens on a clock edge where
  // valid && ready; the producer keeps its payload stable until then.

  typedef struct packed {
    logic              rw;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } sched_cmd_t;

  state_e     state;
  sched_cmd_t in_cmd;
  sched_cmd_t head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       slot_load;
  logic       push;
  logic       pop;
  logic       accept_read;

  assign fsm_state = state;
  assign in_cmd    = {cmd_rw, cmd_op, cmd_data};
  assign slot_load = !exec_valid || exec_ready;

  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE:   cmd_ready = (cmd_rw == CMD_WRITE) ? !fifo_full : (slot_load && fifo_empty);
      ST_RENDER: cmd_ready = (cmd_rw == CMD_WRITE) ? !fifo_full : slot_load;
      default:   cmd_ready = 1'b0;
    endcase
    if (rst_in) cmd_ready = 1'b0;
  end

  assign push        = cmd_valid && cmd_ready && (cmd_rw == CMD_WRITE);
  assign accept_read = cmd_valid && cmd_ready && (cmd_rw == CMD_READ);
  // Held writes stay put while a render is in progress.
  assign pop         = (state != ST_RENDER) && !fifo_empty && slot_load;

  gpu_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .item_t (sched_cmd_t)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (push),
    .wr_data (in_cmd),
    .pop     (pop),
    .rd_data (head_cmd),
    .count   (held_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Pop and a read accept are mutually exclusive: IDLE reads need an empty
  // FIFO and RENDER never pops.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      exec_valid <= 1'b0;
      exec_rw    <= 1'b0;
      exec_op    <= '0;
      exec_data  <= '0;
    end else if (pop) begin
      exec_valid                     <= 1'b1;
      {exec_rw, exec_op, exec_data}  <= head_cmd;
    end else if (accept_read) begin
      exec_valid                     <= 1'b1;
      {exec_rw, exec_op, exec_data}  <= in_cmd;
    end else if (exec_ready) begin
      exec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      frame_gnt <= 1'b0;
      rendering <= 1'b0;
    end else begin
      frame_gnt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Grant once the slot empties this edge with nothing left to pop.
          if (frame_gnt) begin
            state     <= ST_RENDER;
            rendering <= 1'b1;
          end else if (fifo_empty && slot_load) begin
            frame_gnt <= 1'b1;
          end
        end
        ST_RENDER: begin
          if (render_done) begin
            state     <= ST_IDLE;
            rendering <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
